// File: rtl/pipe_ctrl.sv
// Pipeline control: stage stalls, jump/mret redirect, and precise interrupt
// entry (drain to a valid EX instruction, save its PC, redirect to mtvec).
module pipe_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stallreq_id_i,
  input  logic                  stallreq_ex_i,
  input  logic                  stallreq_mem_i,
  input  logic                  jump_req_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  mret_i,
  input  logic [ADDR_WIDTH-1:0] mepc_i,
  input  logic                  int_req_i,
  input  logic                  int_en_i,
  input  logic [ADDR_WIDTH-1:0] mtvec_i,
  input  logic                  ex_valid_i,
  input  logic [ADDR_WIDTH-1:0] ex_pc_i,
  output logic [5:0]            stall_o,
  output logic                  flush_jump_o,
  output logic                  flush_int_o,
  output logic [ADDR_WIDTH-1:0] new_pc_o,
  output logic                  mepc_we_o,
  output logic [ADDR_WIDTH-1:0] mepc_o,
  output logic                  int_active_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    JUMP   = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mepc_q, mepc_d;
  logic                    capture;

  // EX holds an instruction that will complete normally, so its PC is precise.
  assign capture = ex_valid_i & ~stallreq_mem_i & ~jump_req_i & ~mret_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mepc_q  <= '0;
    end else begin
      state_q <= state_d;
      mepc_q  <= mepc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mepc_d  = mepc_q;
    unique case (state_q)
      IDLE: begin
        if (int_req_i && int_en_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!(int_req_i && int_en_i)) begin
          state_d = IDLE;
        end else if (capture) begin
          state_d = JUMP;
          mepc_d  = ex_pc_i;
        end
      end
      JUMP: state_d = ACTIVE;
      ACTIVE: begin
        if (mret_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_o = 6'b000000;
    if (stallreq_mem_i)     stall_o = 6'b011111;
    else if (stallreq_ex_i) stall_o = 6'b001111;
    else if (stallreq_id_i) stall_o = 6'b000111;
  end

  always_comb begin
    new_pc_o = '0;
    if (state_q == JUMP)  new_pc_o = mtvec_i;
    else if (jump_req_i)  new_pc_o = jump_addr_i;
    else if (mret_i)      new_pc_o = mepc_i;
  end

  assign flush_jump_o = (jump_req_i | mret_i) & (state_q != JUMP);
  assign flush_int_o  = (state_q == JUMP);
  assign mepc_we_o    = (state_q == JUMP);
  assign int_active_o = (state_q == ACTIVE);
  assign mepc_o       = mepc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stalls, redirects, interrupt entry/exit, reset.
module tb_pipe_ctrl;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stallreq_id, stallreq_ex, stallreq_mem;
  logic          jump_req, mret, int_req, int_en, ex_valid;
  logic [AW-1:0] jump_addr, mepc_in, mtvec, ex_pc;
  logic [5:0]    stall;
  logic          flush_jump, flush_int, mepc_we, int_active;
  logic [AW-1:0] new_pc, mepc_out;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pipe_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stallreq_id_i  (stallreq_id),
    .stallreq_ex_i  (stallreq_ex),
    .stallreq_mem_i (stallreq_mem),
    .jump_req_i     (jump_req),
    .jump_addr_i    (jump_addr),
    .mret_i         (mret),
    .mepc_i         (mepc_in),
    .int_req_i      (int_req),
    .int_en_i       (int_en),
    .mtvec_i        (mtvec),
    .ex_valid_i     (ex_valid),
    .ex_pc_i        (ex_pc),
    .stall_o        (stall),
    .flush_jump_o   (flush_jump),
    .flush_int_o    (flush_int),
    .new_pc_o       (new_pc),
    .mepc_we_o      (mepc_we),
    .mepc_o         (mepc_out),
    .int_active_o   (int_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then leave 1 time unit so inputs change away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    jump_req = 0; mret = 0; int_req = 0; int_en = 0; ex_valid = 0;
    jump_addr = '0; mepc_in = '0; mtvec = '0; ex_pc = '0;
    #2;
    check("rst_int_active", {31'd0, int_active}, 0);
    check("rst_mepc", mepc_out, 0);
    check("rst_flush_int", {31'd0, flush_int}, 0);
    check("rst_mepc_we", {31'd0, mepc_we}, 0);
    check("rst_stall", {26'd0, stall}, 0);
    check("rst_new_pc", new_pc, 0);
    tick();
    rst = 1'b0;
    tick();

    // stall priority
    stallreq_id = 1; stallreq_mem = 1; #1;
    check("stall_id_mem", {26'd0, stall}, 32'h1F);
    stallreq_mem = 0; #1;
    check("stall_id", {26'd0, stall}, 32'h07);
    stallreq_ex = 1; #1;
    check("stall_ex_id", {26'd0, stall}, 32'h0F);
    stallreq_id = 0; #1;
    check("stall_ex", {26'd0, stall}, 32'h0F);
    stallreq_ex = 0; #1;
    check("stall_none", {26'd0, stall}, 0);

    // jump / mret redirect in IDLE
    jump_req = 1; jump_addr = 32'h100; #1;
    check("jmp_flush", {31'd0, flush_jump}, 1);
    check("jmp_pc", new_pc, 32'h100);
    check("jmp_no_int", {31'd0, flush_int}, 0);
    mret = 1; mepc_in = 32'h80; #1;
    check("jmp_over_mret_pc", new_pc, 32'h100);
    jump_req = 0; #1;
    check("mret_pc", new_pc, 32'h80);
    check("mret_flush", {31'd0, flush_jump}, 1);
    mret = 0; #1;
    check("idle_flush_jump", {31'd0, flush_jump}, 0);
    tick();

    // interrupt entry, 2-cycle latency
    int_en = 1; ex_valid = 1; ex_pc = 32'h40; mtvec = 32'h200; int_req = 1; #1;
    check("ent_c0_flush_int", {31'd0, flush_int}, 0);
    tick();
    check("ent_c1_flush_int", {31'd0, flush_int}, 0);
    check("ent_c1_mepc_we", {31'd0, mepc_we}, 0);
    tick();
    jump_req = 1; jump_addr = 32'h500; #1;
    check("ent_c2_flush_int", {31'd0, flush_int}, 1);
    check("ent_c2_mepc_we", {31'd0, mepc_we}, 1);
    check("ent_c2_mepc", mepc_out, 32'h40);
    check("ent_c2_new_pc", new_pc, 32'h200);
    check("ent_c2_jump_ignored", {31'd0, flush_jump}, 0);
    tick();
    jump_req = 0; #1;
    check("act_int_active", {31'd0, int_active}, 1);
    check("act_flush_int", {31'd0, flush_int}, 0);
    check("act_mepc_we", {31'd0, mepc_we}, 0);
    tick(); tick();
    check("act_int_ignored", {31'd0, int_active}, 1);
    check("act_no_reentry", {31'd0, flush_int}, 0);
    check("act_mepc_kept", mepc_out, 32'h40);
    mret = 1; mepc_in = 32'h40; #1;
    check("mret_act_flush", {31'd0, flush_jump}, 1);
    check("mret_act_pc", new_pc, 32'h40);
    tick();
    mret = 0; int_req = 0; #1;
    check("mret_exit", {31'd0, int_active}, 0);
    tick();

    // entry held off by MEM stall, then by a jump in DRAIN
    int_req = 1; stallreq_mem = 1; ex_pc = 32'h60; #1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("drain_mem_flush_int", {31'd0, flush_int}, 0);
      check("drain_mem_stall", {26'd0, stall}, 32'h1F);
      tick();
    end
    stallreq_mem = 0; jump_req = 1; jump_addr = 32'h300; #1;
    check("drain_jmp_flush", {31'd0, flush_jump}, 1);
    check("drain_jmp_pc", new_pc, 32'h300);
    check("drain_jmp_no_int", {31'd0, flush_int}, 0);
    tick();
    jump_req = 0; ex_pc = 32'h300; #1;
    check("drain_after_jmp", {31'd0, flush_int}, 0);
    tick();
    check("drain_entry_flush", {31'd0, flush_int}, 1);
    check("drain_entry_mepc", mepc_out, 32'h300);
    tick();
    mret = 1; #1;
    tick();
    mret = 0; int_req = 0; #1;
    check("drain_seq_exit", {31'd0, int_active}, 0);
    tick();

    // async reset in DRAIN
    ex_valid = 0; int_req = 1; #1;
    tick(); tick();
    check("pre_rst_mepc", mepc_out, 32'h300);
    #2 rst = 1; ex_valid = 1; #1;
    check("drain_rst_mepc", mepc_out, 0);
    check("drain_rst_active", {31'd0, int_active}, 0);
    check("drain_rst_flush_int", {31'd0, flush_int}, 0);
    tick(); tick();
    check("drain_rst_no_we", {31'd0, mepc_we}, 0);
    rst = 0; int_req = 0; ex_valid = 0; #1;
    tick();

    // DRAIN abandoned when request drops before capture
    int_req = 1; #1;
    tick();
    int_req = 0; #1;
    tick();
    ex_valid = 1; ex_pc = 32'h77; #1;
    tick(); tick();
    check("abandon_no_flush", {31'd0, flush_int}, 0);
    check("abandon_mepc", mepc_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
